// File: rtl/uart_boot_loader_p.sv
// UART boot loader: receives a RAM image over rx, writes it word by word, verifies an
// 8-bit additive checksum, answers ACK/NAK on tx, and can dump the RAM back on request.
module uart_boot_loader_p #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_W       = 8,
  parameter int ADR_W        = 8,
  parameter int DEPTH        = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              rx,
  output logic              tx,
  input  logic              scan_memory,
  output logic              boot,
  input  logic [DATA_W-1:0] ram_out,
  output logic              ram_rw,
  output logic              ram_enable,
  output logic [ADR_W-1:0]  ram_adr,
  output logic [DATA_W-1:0] ram_in,
  output logic              err
);

  localparam int BPW = DATA_W / 8;
  localparam int BCW = $clog2(BPW + 1);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_CLK = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BPW - 1);

  typedef enum logic [3:0] {
    LOAD, CHECK, ACK_TX, NAK_TX, RUN,
    SCAN_RD, SCAN_WAIT, SCAN_CAP, SCAN_TX, SCAN_END
  } state_t;

  state_t state, state_n;

  // ---------------- receiver ----------------
  logic          rx_m, rx_s, rx_prev;
  logic          rx_busy, rx_valid, rx_ferr;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values,
  // independent of statement order inside or across always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (ce) begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= 4'd0;
        end
      end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_CLK : LAST_CLK)) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;  // glitch, not a real start bit
          else      rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_s;
          rx_ferr  <= !rx_s;
        end else begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  // ---------------- transmitter ----------------
  logic          tx_busy, tx_start;
  logic [7:0]    tx_data;
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;

  // The shift register idles all-ones, so tx is high whenever no frame is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (ce) begin
      if (tx_start && !tx_busy) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx_busy  <= 1'b1;
        tx_cnt   <= '0;
        tx_bit   <= 4'd0;
      end else if (tx_busy) begin
        if (tx_cnt == LAST_CLK) begin
          tx_cnt   <= '0;
          tx_shift <= {1'b1, tx_shift[9:1]};
          if (tx_bit == 4'd9) tx_busy <= 1'b0;
          else                tx_bit  <= tx_bit + 4'd1;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  assign tx = tx_shift[0];

  // ---------------- loader control ----------------
  logic [BCW-1:0]    byte_cnt, scan_bcnt;
  logic [ADR_W-1:0]  word_idx, scan_idx;
  logic [7:0]        checksum;
  logic [DATA_W-1:0] word_buf, new_word, scan_buf;
  logic              scan_q, scan_q2, scan_from_run;
  logic              scan_ok, last_byte;

  assign last_byte = (byte_cnt == LAST_BYTE);
  assign new_word  = (word_buf >> 8) | (DATA_W'(rx_shift) << (DATA_W - 8));
  // A byte completing this cycle takes precedence over a scan request.
  assign scan_ok   = scan_q && !scan_q2 && !rx_valid && !tx_busy &&
                     (state == RUN ||
                      (state == LOAD && byte_cnt == '0 && word_idx == '0));
  assign boot      = (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= LOAD;
    else if (ce) state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    case (state)
      LOAD: begin
        if (rx_valid && last_byte && word_idx == LAST_ADR) state_n = CHECK;
        else if (scan_ok)                                  state_n = SCAN_RD;
      end
      CHECK: begin
        if (rx_valid) begin
          tx_start = 1'b1;
          if (rx_shift == checksum) begin
            tx_data = 8'h06;
            state_n = ACK_TX;
          end else begin
            tx_data = 8'h15;
            state_n = NAK_TX;
          end
        end
      end
      ACK_TX:    if (!tx_busy) state_n = RUN;
      NAK_TX:    if (!tx_busy) state_n = LOAD;
      RUN:       if (scan_ok)  state_n = SCAN_RD;
      SCAN_RD:   state_n = SCAN_WAIT;
      SCAN_WAIT: state_n = SCAN_CAP;
      SCAN_CAP:  state_n = SCAN_TX;
      SCAN_TX: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = scan_buf[7:0];
          // Prefetch the next word while the last byte of this one is on the wire.
          if (scan_bcnt == LAST_BYTE)
            state_n = (scan_idx == LAST_ADR) ? SCAN_END : SCAN_RD;
        end
      end
      SCAN_END:  if (!tx_busy) state_n = scan_from_run ? RUN : LOAD;
      default:   state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt      <= '0;
      word_idx      <= '0;
      checksum      <= '0;
      word_buf      <= '0;
      scan_q        <= 1'b0;
      scan_q2       <= 1'b0;
      scan_from_run <= 1'b0;
      scan_idx      <= '0;
      scan_bcnt     <= '0;
      scan_buf      <= '0;
      ram_enable    <= 1'b0;
      ram_rw        <= 1'b0;
      ram_adr       <= '0;
      ram_in        <= '0;
      err           <= 1'b0;
    end else if (ce) begin
      scan_q     <= scan_memory;
      scan_q2    <= scan_q;
      ram_enable <= 1'b0;
      case (state)
        LOAD: begin
          if (rx_valid) begin
            checksum <= checksum + rx_shift;
            word_buf <= new_word;
            if (last_byte) begin
              byte_cnt   <= '0;
              ram_enable <= 1'b1;
              ram_rw     <= 1'b1;
              ram_adr    <= word_idx;
              ram_in     <= new_word;
              if (word_idx != LAST_ADR) word_idx <= word_idx + 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (scan_ok) begin
            scan_from_run <= 1'b0;
            scan_idx      <= '0;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (rx_shift == checksum) begin
              err <= 1'b0;
            end else begin
              err      <= 1'b1;
              word_idx <= '0;
              byte_cnt <= '0;
              checksum <= '0;
            end
          end
        end
        RUN: begin
          if (scan_ok) begin
            scan_from_run <= 1'b1;
            scan_idx      <= '0;
          end
        end
        SCAN_RD: begin
          ram_enable <= 1'b1;
          ram_rw     <= 1'b0;
          ram_adr    <= scan_idx;
        end
        SCAN_CAP: begin
          scan_buf  <= ram_out;
          scan_bcnt <= '0;
        end
        SCAN_TX: begin
          if (!tx_busy) begin
            scan_buf  <= scan_buf >> 8;
            scan_bcnt <= scan_bcnt + 1'b1;
            if (scan_bcnt == LAST_BYTE && scan_idx != LAST_ADR) scan_idx <= scan_idx + 1'b1;
          end
        end
        default: ;
      endcase
      if (rx_ferr) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader_p.sv
// Self-checking bench for uart_boot_loader_p: table-driven loads, hand-written corner
// sequences and randomized streams checked against a byte/word level model.
module tb_uart_boot_loader_p;

  localparam int CPB   = 4;
  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam logic [63:0] STD = 64'h0807060504030201;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b1;
  logic          rx = 1'b1;
  logic          scan_memory = 1'b0;
  logic [DW-1:0] ram_out = '0;
  logic          tx, boot, ram_rw, ram_enable, err;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_in;

  always #5 clk = ~clk;

  uart_boot_loader_p #(
    .CLKS_PER_BIT(CPB), .DATA_W(DW), .ADR_W(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .rx(rx), .tx(tx), .scan_memory(scan_memory),
    .boot(boot), .ram_out(ram_out), .ram_rw(ram_rw), .ram_enable(ram_enable),
    .ram_adr(ram_adr), .ram_in(ram_in), .err(err)
  );

  // Program RAM: read data appears the cycle after the strobe.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_rw) mem[ram_adr] <= ram_in;
      else        ram_out      <= mem[ram_adr];
    end
  end

  // RAM access log, sampled mid-cycle.
  logic [AW+DW-1:0] wr_q [$];
  int   rd_cnt = 0;
  int   dbl_en = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (ram_enable && ram_rw)  wr_q.push_back({ram_adr, ram_in});
    if (ram_enable && !ram_rw) rd_cnt++;
    if (ram_enable && prev_en) dbl_en++;
    prev_en = ram_enable;
  end

  // UART decoder on tx, sampling each bit in its middle.
  logic [7:0] tx_q [$];
  logic       boot_at_stop = 1'b0;
  always begin : tx_mon
    logic [7:0] b;
    @(negedge tx);
    repeat (2) @(negedge clk);
    if (tx == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      boot_at_stop = boot;
      tx_q.push_back(b);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: little-endian word packing and mod-256 byte sum.
  function automatic logic [DW-1:0] exp_word(input logic [63:0] bs, input int i);
    return {bs[8*(2*i+1) +: 8], bs[8*(2*i) +: 8]};
  endfunction

  function automatic logic [7:0] sum8(input logic [63:0] bs);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 8; i++) s = s + bs[8*i +: 8];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int pause_bit);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == pause_bit) begin
        tick(2);
        ce = 1'b0;
        tick(20);
        ce = 1'b1;
        tick(CPB - 2);
      end else begin
        tick(CPB);
      end
    end
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic wait_tx(input int base, input int n, input int budget, input string name);
    int c = 0;
    while (tx_q.size() < base + n && c < budget) begin
      tick(1);
      c++;
    end
    check(name, tx_q.size() - base, n);
  endtask

  task automatic check_words(input int w0, input logic [63:0] bs);
    check("wr_count", wr_q.size() - w0, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (wr_q.size() > w0 + i) check("wr_word", wr_q[w0+i], {AW'(i), exp_word(bs, i)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic run_load(input logic [63:0] bs, input logic [7:0] cks, input logic [7:0] resp,
                          input logic e, input logic bt, input int pause_idx);
    int t0, w0;
    t0 = tx_q.size();
    w0 = wr_q.size();
    for (int i = 0; i < 8; i++) send_byte(bs[8*i +: 8], 1'b1, (i == pause_idx) ? 5 : -1);
    send_byte(cks, 1'b1, -1);
    wait_tx(t0, 1, 300, "resp_frame");
    if (tx_q.size() > t0) check("resp_byte", tx_q[t0], resp);
    check("boot_at_resp_stop", boot_at_stop, 1);
    tick(10);
    check("err", err, e);
    check("boot", boot, bt);
    check_words(w0, bs);
  endtask

  task automatic do_scan(input logic chk, input logic [63:0] bs, input logic bt_after);
    int t0, r0, c;
    logic lo;
    t0 = tx_q.size();
    r0 = rd_cnt;
    lo = 1'b0;
    c  = 0;
    scan_memory = 1'b1;
    tick(5);
    while (tx_q.size() < t0 + 8 && c < 2000) begin
      tick(1);
      c++;
      if (!boot) lo = 1'b1;
    end
    check("scan_bytes", tx_q.size() - t0, 8);
    check("scan_boot_low_seen", lo, 0);
    if (chk)
      for (int i = 0; i < 8; i++)
        if (tx_q.size() > t0 + i) check("scan_data", tx_q[t0+i], bs[8*i +: 8]);
    tick(100);
    check("scan_reads", rd_cnt - r0, DEPTH);
    check("scan_no_retrigger", tx_q.size() - t0, 8);
    check("boot_after_scan", boot, bt_after);
    scan_memory = 1'b0;
    tick(5);
  endtask

  typedef struct packed {
    logic [63:0] bytes;
    logic [7:0]  cks;
    logic [7:0]  resp;
    logic        err;
    logic        boot;
  } vec_t;

  vec_t vt [6];

  initial begin
    int w0, t0;
    logic [63:0] rb;
    logic [7:0]  rc, rs;
    logic        good;

    vt[0] = '{bytes: STD,                   cks: 8'h24, resp: 8'h06, err: 1'b0, boot: 1'b0};
    vt[1] = '{bytes: STD,                   cks: 8'h25, resp: 8'h15, err: 1'b1, boot: 1'b1};
    vt[2] = '{bytes: 64'hFFFFFFFFFFFFFFFF,  cks: 8'hF8, resp: 8'h06, err: 1'b0, boot: 1'b0};
    vt[3] = '{bytes: 64'h0,                 cks: 8'h00, resp: 8'h06, err: 1'b0, boot: 1'b0};
    vt[4] = '{bytes: 64'h8070605040302010,  cks: 8'h40, resp: 8'h06, err: 1'b0, boot: 1'b0};
    vt[5] = '{bytes: 64'h55AA55AA55AA55AA,  cks: 8'h00, resp: 8'h15, err: 1'b1, boot: 1'b1};

    tick(3);
    check("reset_outputs", {boot, tx, ram_enable, ram_rw, ram_adr, ram_in, err},
          {1'b1, 1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0});
    rst = 1'b0;
    tick(2);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_load(vt[v].bytes, vt[v].cks, vt[v].resp, vt[v].err, vt[v].boot, -1);
    end

    // NAK then a clean reload.
    do_reset();
    run_load(STD, 8'h25, 8'h15, 1'b1, 1'b1, -1);
    run_load(STD, 8'h24, 8'h06, 1'b0, 1'b0, -1);

    // Framing error on the third byte leaves the load position untouched.
    do_reset();
    w0 = wr_q.size();
    t0 = tx_q.size();
    send_byte(8'h01, 1'b1, -1);
    send_byte(8'h02, 1'b1, -1);
    send_byte(8'h03, 1'b0, -1);
    tick(4);
    check("ferr_err", err, 1);
    check("ferr_writes", wr_q.size() - w0, 1);
    for (int i = 2; i < 8; i++) send_byte(STD[8*i +: 8], 1'b1, -1);
    send_byte(8'h24, 1'b1, -1);
    wait_tx(t0, 1, 300, "ferr_resp_frame");
    if (tx_q.size() > t0) check("ferr_resp_byte", tx_q[t0], 8'h06);
    tick(10);
    check("ferr_err_cleared", err, 0);
    check("ferr_boot", boot, 0);
    check_words(w0, STD);

    // Dump after a successful load.
    do_reset();
    run_load(STD, 8'h24, 8'h06, 1'b0, 1'b0, -1);
    do_scan(1'b1, STD, 1'b0);

    // Dump from LOAD with nothing received, then a normal load still works.
    do_reset();
    do_scan(1'b1, STD, 1'b1);
    run_load(STD, 8'h24, 8'h06, 1'b0, 1'b0, -1);

    // Clock enable held low for 20 cycles inside the fourth byte.
    do_reset();
    run_load(STD, 8'h24, 8'h06, 1'b0, 1'b0, 3);

    // Reset in the middle of a frame, after one word was written.
    do_reset();
    send_byte(8'h01, 1'b1, -1);
    send_byte(8'h02, 1'b1, -1);
    rx = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("midload_reset_outputs", {boot, tx, ram_enable, ram_rw, ram_adr, ram_in, err},
          {1'b1, 1'b1, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0});
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    run_load(STD, 8'h24, 8'h06, 1'b0, 1'b0, -1);

    // Randomized images with random checksum correctness.
    for (int r = 0; r < 4; r++) begin
      rb   = {$urandom, $urandom};
      good = 1'($urandom_range(0, 1));
      rs   = sum8(rb);
      rc   = good ? rs : rs + 8'($urandom_range(1, 255));
      do_reset();
      run_load(rb, rc, good ? 8'h06 : 8'h15, !good, !good, -1);
      if (good) do_scan(1'b1, rb, 1'b0);
    end

    check("ram_enable_single_cycle", dbl_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader_p.md
Name: uart_boot_loader_p

Overview:
Parametrised UART boot loader that sits between the top-level pins and the program RAM. After reset it holds the core in boot, receives a RAM image over `rx`, writes it word by word, verifies an 8-bit checksum, and answers ACK or NAK on `tx`. It then releases `boot`. A `scan_memory` request dumps the full RAM back over `tx`. Generalises the fixed-width loader to any word width, depth and baud divisor, and adds checksum verification and error reporting.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (>=4); 8N1 framing.
DATA_W, 8, RAM word width; multiple of 8. BPW = DATA_W/8 bytes per word.
ADR_W, 8, RAM address width.
DEPTH, 256, words loaded/scanned; 1 <= DEPTH <= 2^ADR_W.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ce  in  1  clock enable; 0 freezes all state (outputs hold)
rx  in  1  UART receive, idle high, asynchronous to clk
tx  out  1  UART transmit, idle high
scan_memory  in  1  level request for RAM dump; rising edge acts
boot  out  1  1 = core held in boot (loader owns RAM)
ram_out  in  DATA_W  RAM read data, valid the cycle after a read strobe
ram_rw  out  1  1 = write, 0 = read
ram_enable  out  1  one-cycle RAM access strobe
ram_adr  out  ADR_W  RAM address
ram_in  out  DATA_W  RAM write data
err  out  1  sticky: framing error or NAK since last ACK

Behaviour:
- Reset values:
  - Outputs: boot=1, tx=1, ram_enable=0, ram_rw=0, ram_adr=0, ram_in=0, err=0.
  - Internal state: FSM=LOAD, byte counter=0, checksum=0.
  - Reset is honoured mid-frame and mid-TX. `tx` returns high immediately.
- When ce=0, nothing advances, including baud counters and the synchroniser.
- RX path:
  - 2-FF synchroniser on `rx`, then falling-edge start detect.
  - Re-sample at CLKS_PER_BIT/2; if high, false start, return to idle.
  - Sample data bits LSB first, one every CLKS_PER_BIT.
  - If the stop bit samples 0: discard the byte, set err=1, and leave all counters unchanged.
- TX path: 8N1 frame, LSB first, each bit held CLKS_PER_BIT cycles. A busy flag gates new bytes.
- States:
  - LOAD
    - Each received byte is added to the checksum (mod 256) and shifted into the word buffer, little-endian (first byte to bits [7:0]).
    - On the BPW-th byte, assert a one-cycle write the next cycle: ram_enable=1, ram_rw=1, ram_adr=word index, ram_in=word. Then increment the word index.
    - After DEPTH words, go to CHECK.
  - CHECK: the next received byte is compared with the checksum.
    - Equal: send 0x06, then go to RUN. err clears when the ACK is queued.
    - Not equal: send 0x15, set err=1, clear word index, byte counter and checksum, then go to LOAD.
  - ACK_TX / NAK_TX
    - Wait until the stop bit is complete. boot falls to 0 on the cycle after the ACK stop bit ends.
    - Bytes received during these states are discarded.
  - RUN: boot=0. Received bytes are ignored.
  - SCAN
    - Entered on a registered rising edge of scan_memory, from RUN or from LOAD with zero bytes received. Ignored in any other state or while TX is busy.
    - boot=1 for the whole dump.
    - Per word:
      - Read strobe: ram_enable=1, ram_rw=0, ram_adr=index.
      - Capture ram_out one cycle later.
      - Transmit BPW bytes, little-endian, with at most 2 idle cycles between frames.
    - After word DEPTH-1, return to the originating state. Returning to RUN drops boot to 0.
    - A scan_memory level held high does not retrigger.
- Simultaneous events:
  - A byte completes on the same cycle as a scan edge: the byte wins and the scan request is dropped.
  - The word index saturates at DEPTH-1. No wrap beyond DEPTH.
- ram_enable is never high for more than one consecutive cycle. ram_in holds the last written word.

Test Plan:
- Common settings: CLKS_PER_BIT=4, DATA_W=16, ADR_W=2, DEPTH=4.
- Happy load: send 01 02 03 04 05 06 07 08, then checksum 0x24 → writes 0x0201@0, 0x0403@1, 0x0605@2, 0x0807@3, one ram_enable pulse each; tx sends 0x06; boot 1→0 after the ACK stop bit; err=0.
- Bad checksum: same 8 bytes, then 0x25 → tx sends 0x15; err=1; boot stays 1. A reload with 0x24 then ACKs, clears err and releases boot.
- Framing error: 3rd byte sent with stop bit 0 → no counter or checksum change, err=1. Resending the full correct stream still yields ACK.
- Scan dump: after load, pulse scan_memory with the RAM model returning the loaded data → tx emits 01 02 03 04 05 06 07 08; boot=1 during the dump, 0 after; exactly 4 read strobes (ram_rw=0).
- ce and reset: hold ce=0 for 20 cycles mid-byte → the byte is still received correctly once ce=1. Assert rst mid-load → all outputs return to reset values; the load restarts at address 0.
